// File: rtl/vga_pkg.sv
// vga_pkg: constants and helpers shared by the VGA text renderer.
//   - 640x480@60 Hz horizontal/vertical visible, porch and sync lengths
//   - character code constants (6-bit codes, six slots per word)
//   - RGB444 pixel type
//   - slot_code(): pick one 6-bit code out of the 36-bit code word
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FPORCH  = 16;
  localparam int H_SYNC_W  = 96;
  localparam int H_BPORCH  = 48;

  localparam int V_VISIBLE = 480;
  localparam int V_FPORCH  = 10;
  localparam int V_SYNC_W  = 2;
  localparam int V_BPORCH  = 33;

  // Both raster counters fit in 10 bits (800 columns, 525 lines).
  localparam int CNT_W = 10;

  localparam int CODE_W    = 6;
  localparam int NUM_SLOTS = 6;
  localparam int WORD_W    = CODE_W * NUM_SLOTS;

  localparam logic [CODE_W-1:0] CODE_SPACE = 6'd62;
  localparam logic [CODE_W-1:0] CODE_A     = 6'd10;

  // Power-up / reset contents of the frame latch: six spaces.
  localparam logic [WORD_W-1:0] CODES_BLANK = {NUM_SLOTS{CODE_SPACE}};

  localparam int RGB_W = 12;
  typedef logic [RGB_W-1:0] rgb444_t;

  // Slot 0 is the leftmost character and lives in the top bits of the word.
  // Slots 6 and 7 never occur inside the text box; they map to a space.
  function automatic logic [CODE_W-1:0] slot_code(input logic [WORD_W-1:0] codes,
                                                  input logic [2:0]        slot);
    case (slot)
      3'd0:    return codes[35:30];
      3'd1:    return codes[29:24];
      3'd2:    return codes[23:18];
      3'd3:    return codes[17:12];
      3'd4:    return codes[11:6];
      3'd5:    return codes[5:0];
      default: return CODE_SPACE;
    endcase
  endfunction

endpackage

// File: rtl/vga_font_rom.sv
// vga_font_rom: combinational 8x8 glyph table for the 64-entry character code
// space. Codes 0-9 are the digits, 10-35 the letters A-Z; every other code
// (including the space code) returns an empty row.
//   code : 6-bit character code
//   row  : glyph row, 0 = top
//   bits : row pattern, bit 7 = leftmost pixel column
module vga_font_rom
  import vga_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic [2:0]        row,
  output logic [7:0]        bits
);

  // Each glyph is eight row bytes, row 0 in the most significant byte.
  logic [63:0] glyph;

  always_comb begin
    glyph = 64'h0;
    case (code)
      6'd0:  glyph = 64'h3C666E7666663C00;
      6'd1:  glyph = 64'h183818181818_7E00;
      6'd2:  glyph = 64'h3C66060C30607E00;
      6'd3:  glyph = 64'h3C66061C06663C00;
      6'd4:  glyph = 64'h0C1C3C6C7E0C0C00;
      6'd5:  glyph = 64'h7E607C0606663C00;
      6'd6:  glyph = 64'h3C60607C66663C00;
      6'd7:  glyph = 64'h7E060C1830303000;
      6'd8:  glyph = 64'h3C66663C66663C00;
      6'd9:  glyph = 64'h3C66663E060C3800;
      6'd10: glyph = 64'h183C66667E666600; // A
      6'd11: glyph = 64'h7C66667C66667C00;
      6'd12: glyph = 64'h3C66606060663C00;
      6'd13: glyph = 64'h786C6666666C7800;
      6'd14: glyph = 64'h7E60607C60607E00;
      6'd15: glyph = 64'h7E60607C60606000;
      6'd16: glyph = 64'h3C66606E66663E00;
      6'd17: glyph = 64'h6666667E66666600;
      6'd18: glyph = 64'h3C18181818183C00;
      6'd19: glyph = 64'h1E0C0C0C6C6C3800;
      6'd20: glyph = 64'h666C7870786C6600;
      6'd21: glyph = 64'h6060606060607E00;
      6'd22: glyph = 64'h63777F6B63636300;
      6'd23: glyph = 64'h66767E7E6E666600;
      6'd24: glyph = 64'h3C66666666663C00;
      6'd25: glyph = 64'h7C66667C60606000;
      6'd26: glyph = 64'h3C6666666A6C3600;
      6'd27: glyph = 64'h7C66667C786C6600;
      6'd28: glyph = 64'h3C66603C06663C00;
      6'd29: glyph = 64'h7E18181818181800; // T
      6'd30: glyph = 64'h6666666666663C00;
      6'd31: glyph = 64'h66666666663C1800;
      6'd32: glyph = 64'h6363636B7F776300;
      6'd33: glyph = 64'h66663C183C666600;
      6'd34: glyph = 64'h6666663C18181800;
      6'd35: glyph = 64'h7E060C1830607E00; // Z
      default: glyph = 64'h0;
    endcase
    // ~row == 7 - row: row 0 selects the top byte.
    bits = glyph[{~row, 3'b000} +: 8];
  end

endmodule

// File: rtl/vga_text_render.sv
// vga_text_render: 640x480@60 Hz VGA timing plus a single line of six scaled
// characters drawn on a coloured box.
//   clk        : system clock (100 MHz nominal)
//   rst        : asynchronous reset, active-high
//   char_codes : six 6-bit codes, [35:30] = leftmost slot
//   vga_hs/vs  : active-low syncs, aligned with the RGB outputs
//   vga_r/g/b  : 4-bit colour channels, 0 outside the text box / blanking
// The raster timing parameters default to the standard mode; they exist so a
// reduced raster can be built around the same pipeline.
module vga_text_render
  import vga_pkg::*;
#(
  parameter int      CLK_DIV  = 4,
  parameter int      SCALE    = 4,
  parameter int      TEXT_X0  = 224,
  parameter int      TEXT_Y0  = 224,
  parameter rgb444_t FG_COLOR = 12'hFFF,
  parameter rgb444_t BG_COLOR = 12'h00F,
  parameter int      H_VIS    = H_VISIBLE,
  parameter int      H_FP     = H_FPORCH,
  parameter int      H_SW     = H_SYNC_W,
  parameter int      H_BP     = H_BPORCH,
  parameter int      V_VIS    = V_VISIBLE,
  parameter int      V_FP     = V_FPORCH,
  parameter int      V_SW     = V_SYNC_W,
  parameter int      V_BP     = V_BPORCH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [35:0] char_codes,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SW + V_BP;

  localparam int SCALE_SH = $clog2(SCALE);
  localparam int CELL_SH  = SCALE_SH + 3;
  localparam int BOX_W    = NUM_SLOTS * 8 * SCALE;
  localparam int BOX_H    = 8 * SCALE;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SW);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SW);
  localparam logic [CNT_W-1:0] X_LO     = CNT_W'(TEXT_X0);
  localparam logic [CNT_W-1:0] X_HI     = CNT_W'(TEXT_X0 + BOX_W);
  localparam logic [CNT_W-1:0] Y_LO     = CNT_W'(TEXT_Y0);
  localparam logic [CNT_W-1:0] Y_HI     = CNT_W'(TEXT_Y0 + BOX_H);

  // Elaboration-time legality checks; nothing here is built into hardware.
  if (TEXT_X0 < 0 || TEXT_Y0 < 0 ||
      TEXT_X0 + BOX_W > H_VIS || TEXT_Y0 + BOX_H > V_VIS) begin : g_box_outside
    $error("vga_text_render: text box does not fit inside the visible area");
  end
  if (SCALE < 1 || (1 << SCALE_SH) != SCALE) begin : g_scale_not_pow2
    $error("vga_text_render: SCALE must be a power of two");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_text_render: CLK_DIV must be at least 1");
  end
  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_cnt_overflow
    $error("vga_text_render: raster does not fit the counter width");
  end

  logic [DIV_W-1:0]  div_cnt;
  logic              pix_en;
  logic [CNT_W-1:0]  h_cnt;
  logic [CNT_W-1:0]  v_cnt;
  logic [WORD_W-1:0] code_reg;

  assign pix_en = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // ---- Stage 0: raster counters ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  // The code word is only taken at the start of vertical blanking, so a
  // frame always shows one consistent word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_reg <= CODES_BLANK;
    end else if (pix_en && h_cnt == '0 && v_cnt == V_ACT) begin
      code_reg <= char_codes;
    end
  end

  logic [CNT_W-1:0]  dx_s0;
  logic [CNT_W-1:0]  dy_s0;
  logic              in_box_s0;
  logic              active_s0;
  logic              hs_s0;
  logic              vs_s0;
  logic [2:0]        slot_s0;

  // Offsets are only meaningful inside the box; outside it they wrap and
  // are ignored because in_box gates the colour.
  assign dx_s0     = h_cnt - X_LO;
  assign dy_s0     = v_cnt - Y_LO;
  assign in_box_s0 = (h_cnt >= X_LO) && (h_cnt < X_HI) &&
                     (v_cnt >= Y_LO) && (v_cnt < Y_HI);
  assign active_s0 = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_s0     = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vs_s0     = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
  assign slot_s0   = 3'(dx_s0 >> CELL_SH);

  // ---- Stage 1: character/glyph coordinates and sync ----
  logic              active_p1;
  logic              in_box_p1;
  logic              hs_p1;
  logic              vs_p1;
  logic [CODE_W-1:0] code_p1;
  logic [2:0]        row_p1;
  logic [2:0]        col_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_p1 <= 1'b0;
      in_box_p1 <= 1'b0;
      hs_p1     <= 1'b1;
      vs_p1     <= 1'b1;
    end else if (pix_en) begin
      active_p1 <= active_s0;
      in_box_p1 <= in_box_s0;
      hs_p1     <= hs_s0;
      vs_p1     <= vs_s0;
    end
  end

  always_ff @(posedge clk) begin
    if (pix_en) begin
      code_p1 <= slot_code(code_reg, slot_s0);
      row_p1  <= dy_s0[SCALE_SH +: 3];
      col_p1  <= dx_s0[SCALE_SH +: 3];
    end
  end

  // ---- Stage 2: font lookup, colour select, output registers ----
  logic [7:0] glyph_row;
  logic       pix_bit;
  rgb444_t    rgb_s1;
  rgb444_t    rgb_p2;
  logic       hs_p2;
  logic       vs_p2;

  vga_font_rom u_font (
    .code (code_p1),
    .row  (row_p1),
    .bits (glyph_row)
  );

  // ~col == 7 - col: column 0 is the MSB of the row byte.
  assign pix_bit = glyph_row[~col_p1];

  always_comb begin
    rgb_s1 = '0;
    if (active_p1 && in_box_p1) begin
      rgb_s1 = pix_bit ? FG_COLOR : BG_COLOR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_p2 <= '0;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
    end else if (pix_en) begin
      rgb_p2 <= rgb_s1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
    end
  end

  assign vga_hs = hs_p2;
  assign vga_vs = vs_p2;
  assign vga_r  = rgb_p2[11:8];
  assign vga_g  = rgb_p2[7:4];
  assign vga_b  = rgb_p2[3:0];

endmodule

// File: tb/tb_vga_text_render.sv
// Scoreboard bench for vga_text_render on a reduced raster.
// A reference process derives, from the pixel tick count since reset, the
// expected sync/colour for every clock and queues it; a monitor on the
// falling edge pops and compares, and also measures sync pulse widths and
// periods and the reset values of the outputs.
`timescale 1ns/1ps
module tb_vga_text_render;

  localparam int CLK_DIV = 2;
  localparam int SCALE   = 2;
  localparam int X0      = 4;
  localparam int Y0      = 2;
  localparam int HV = 104, HFP = 4, HSW = 8, HBP = 4;
  localparam int VV = 20,  VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HV + HFP + HSW + HBP;
  localparam int VT = VV + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam int FRAME_CLK = FT * CLK_DIV;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h00F;
  localparam logic [35:0] SPACES = {6{6'd62}};
  localparam logic [35:0] TEST3  = 36'b011101_001110_011100_011101_111110_000011;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [11:0] rgb;
  } obs_t;

  localparam obs_t RESET_OBS = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [35:0] char_codes = '0;
  logic        vga_hs;
  logic        vga_vs;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;

  int errors = 0;
  int checks = 0;

  obs_t        sb_q[$];
  logic [63:0] font [0:35];

  always #5 clk = ~clk;

  vga_text_render #(
    .CLK_DIV (CLK_DIV), .SCALE (SCALE), .TEXT_X0 (X0), .TEXT_Y0 (Y0),
    .FG_COLOR (FG), .BG_COLOR (BG),
    .H_VIS (HV), .H_FP (HFP), .H_SW (HSW), .H_BP (HBP),
    .V_VIS (VV), .V_FP (VFP), .V_SW (VSW), .V_BP (VBP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .char_codes (char_codes),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b)
  );

  initial begin
    font[0]  = 64'h3C666E7666663C00; font[1]  = 64'h1838181818187E00;
    font[2]  = 64'h3C66060C30607E00; font[3]  = 64'h3C66061C06663C00;
    font[4]  = 64'h0C1C3C6C7E0C0C00; font[5]  = 64'h7E607C0606663C00;
    font[6]  = 64'h3C60607C66663C00; font[7]  = 64'h7E060C1830303000;
    font[8]  = 64'h3C66663C66663C00; font[9]  = 64'h3C66663E060C3800;
    font[10] = 64'h183C66667E666600; font[11] = 64'h7C66667C66667C00;
    font[12] = 64'h3C66606060663C00; font[13] = 64'h786C6666666C7800;
    font[14] = 64'h7E60607C60607E00; font[15] = 64'h7E60607C60606000;
    font[16] = 64'h3C66606E66663E00; font[17] = 64'h6666667E66666600;
    font[18] = 64'h3C18181818183C00; font[19] = 64'h1E0C0C0C6C6C3800;
    font[20] = 64'h666C7870786C6600; font[21] = 64'h6060606060607E00;
    font[22] = 64'h63777F6B63636300; font[23] = 64'h66767E7E6E666600;
    font[24] = 64'h3C66666666663C00; font[25] = 64'h7C66667C60606000;
    font[26] = 64'h3C6666666A6C3600; font[27] = 64'h7C66667C786C6600;
    font[28] = 64'h3C66603C06663C00; font[29] = 64'h7E18181818181800;
    font[30] = 64'h6666666666663C00; font[31] = 64'h66666666663C1800;
    font[32] = 64'h6363636B7F776300; font[33] = 64'h66663C183C666600;
    font[34] = 64'h6666663C18181800; font[35] = 64'h7E060C1830607E00;
  end

  // Expected output for raster position pos (0 = top-left of a frame).
  function automatic obs_t expect_pixel(input int pos, input logic [35:0] codes);
    int         h, v, slot, col, row;
    logic [5:0] code;
    obs_t       o;
    h = pos % HT;
    v = pos / HT;
    o.hs  = !(h >= HV + HFP && h < HV + HFP + HSW);
    o.vs  = !(v >= VV + VFP && v < VV + VFP + VSW);
    o.rgb = 12'h000;
    if (h < HV && v < VV && h >= X0 && h < X0 + 48 * SCALE &&
        v >= Y0 && v < Y0 + 8 * SCALE) begin
      slot = (h - X0) / (8 * SCALE);
      col  = ((h - X0) % (8 * SCALE)) / SCALE;
      row  = (v - Y0) / SCALE;
      code = codes[35 - 6 * slot -: 6];
      o.rgb = BG;
      if (code <= 6'd35) begin
        if (font[code][63 - 8 * row - col]) o.rgb = FG;
      end
    end
    return o;
  endfunction

  // Reference: pixel ticks fall every CLK_DIV clocks after reset release;
  // the output after tick j shows the raster position of tick j-2.
  int unsigned clks;
  int unsigned kpix;
  int          pos_before;
  logic [35:0] frame_codes;
  obs_t        exp_now;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      clks        = 0;
      kpix        = 0;
      frame_codes = SPACES;
      exp_now     = RESET_OBS;
      sb_q.delete();
    end else begin
      clks = clks + 1;
      if (clks % CLK_DIV == 0) begin
        pos_before = int'(kpix % FT);
        if (pos_before == VV * HT) frame_codes = char_codes;
        kpix = kpix + 1;
        if (kpix >= 2) exp_now = expect_pixel(int'((kpix - 2) % FT), frame_codes);
        else           exp_now = RESET_OBS;
      end
      sb_q.push_back(exp_now);
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks = checks + 1;
    if (got != want) begin
      errors = errors + 1;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
    end
  endtask

  // Monitor: scoreboard compare plus sync width/period measurement.
  obs_t        got_obs;
  obs_t        want_obs;
  int unsigned ncyc = 0;
  int unsigned hs_fall_t, vs_fall_t;
  bit          hs_seen = 0, vs_seen = 0;
  logic        hs_prev = 1'b1, vs_prev = 1'b1;

  always @(negedge clk) begin
    ncyc    = ncyc + 1;
    got_obs = '{hs: vga_hs, vs: vga_vs, rgb: {vga_r, vga_g, vga_b}};
    if (rst) begin
      chk("reset_outputs", int'(got_obs), int'(RESET_OBS));
      hs_seen = 0;
      vs_seen = 0;
      hs_prev = 1'b1;
      vs_prev = 1'b1;
    end else begin
      if (sb_q.size() > 0) begin
        want_obs = sb_q.pop_front();
        chk("pixel", int'(got_obs), int'(want_obs));
      end
      if (hs_prev && !vga_hs) begin
        if (hs_seen) chk("hs_period_clk", int'(ncyc - hs_fall_t), HT * CLK_DIV);
        hs_fall_t = ncyc;
        hs_seen   = 1;
      end
      if (!hs_prev && vga_hs && hs_seen)
        chk("hs_width_clk", int'(ncyc - hs_fall_t), HSW * CLK_DIV);
      if (vs_prev && !vga_vs) begin
        if (vs_seen) chk("vs_period_clk", int'(ncyc - vs_fall_t), FRAME_CLK);
        vs_fall_t = ncyc;
        vs_seen   = 1;
      end
      if (!vs_prev && vga_vs && vs_seen)
        chk("vs_width_clk", int'(ncyc - vs_fall_t), VSW * HT * CLK_DIV);
      hs_prev = vga_hs;
      vs_prev = vga_vs;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [35:0] rand_codes(input bit full_range);
    logic [35:0] w;
    w = '0;
    for (int i = 0; i < 6; i++) begin
      w = {w[29:0], (full_range ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 35)))};
    end
    return w;
  endfunction

  logic [35:0] w;

  initial begin
    char_codes = rand_codes(1'b0);
    wait_clks(10);
    rst = 1'b0;

    // Frame 0 keeps spaces even though the word changes mid-frame.
    wait_clks(10 * HT * CLK_DIV);
    char_codes = TEST3;

    // Frame 1 shows TEST 3; load a word with an unmapped code in slot 2.
    wait_clks(FRAME_CLK);
    w = rand_codes(1'b0);
    w[23:18] = 6'd40;
    char_codes = w;

    wait_clks(FRAME_CLK);
    char_codes = rand_codes(1'b1);
    wait_clks(FRAME_CLK);
    char_codes = rand_codes(1'b0);

    // Mid-frame reset at line 15 of frame 4.
    wait_clks(FRAME_CLK + 5 * HT * CLK_DIV);
    char_codes = rand_codes(1'b0);
    rst = 1'b1;
    wait_clks(5);
    rst = 1'b0;

    wait_clks(10 * HT * CLK_DIV);
    char_codes = rand_codes(1'b0);
    wait_clks(FRAME_CLK);
    char_codes = rand_codes(1'b1);
    wait_clks(FRAME_CLK + 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_text_render.md
Name: vga_text_render

Overview:
- Downstream consumer of the six-character 36-bit code word from the testcase/status encoder.
- Generates 640x480@60 Hz VGA timing from the 100 MHz system clock, with a /4 pixel enable.
- Renders the six characters as a single scaled text line on a box background; drives 12-bit RGB plus sync to the board VGA connector.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz pixel tick)
- SCALE, 4, glyph magnification (8x8 font -> 32x32 cell)
- TEXT_X0, 224, left pixel column of character slot 0
- TEXT_Y0, 224, top pixel row of the text line
- FG_COLOR, 12'hFFF, RGB444 of glyph pixels
- BG_COLOR, 12'h00F, RGB444 of non-glyph pixels inside the text box

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous reset, active-high
- char_codes  in  36  six 6-bit codes; [35:30] = slot 0 (leftmost) ... [5:0] = slot 5
- vga_hs  out  1  horizontal sync, active-low
- vga_vs  out  1  vertical sync, active-low
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue

Behaviour:
- Code map:
  - 0-9 = digits '0'-'9'.
  - 10-35 = 'A'-'Z'.
  - 62 = space.
  - Codes 36-61 and 63 render as space (all BG).
- Reset (async, rst=1):
  - div_cnt=0, h_cnt=0, v_cnt=0.
  - vga_hs=1, vga_vs=1, RGB=0.
  - Frame-latched codes = six spaces (36'b111110 repeated).
- Pixel tick: pix_en=1 when div_cnt==CLK_DIV-1. div_cnt wraps to 0 on that cycle. All state below advances only on pix_en.
- Horizontal counter h_cnt 0..799, wraps at 799.
  - Visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
- Vertical counter v_cnt 0..524. Increments when h_cnt wraps and itself wraps at 524.
  - Visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
- Frame latch: char_codes is sampled into the internal code register on the pix_en where h_cnt==0 and v_cnt==480.
  - Input changes at any other time do not alter the current frame (no tearing).
- Text box: x in [TEXT_X0, TEXT_X0+6*8*SCALE), y in [TEXT_Y0, TEXT_Y0+8*SCALE).
  - slot = (x-TEXT_X0)/(8*SCALE)
  - glyph col = ((x-TEXT_X0)%(8*SCALE))/SCALE
  - glyph row = (y-TEXT_Y0)/SCALE
  - With SCALE a power of two, all divisions are shifts. Slot division by 32 uses no divider.
- Pipeline, per pix_en:
  - S0: h_cnt/v_cnt.
  - S1: register code, glyph row, glyph col, in_box, active, hs, vs.
  - S2: font lookup; register RGB and sync to the outputs.
  - Total latency is 2 pixel ticks from counter value to output. Sync and RGB stay aligned.
- Pixel colour in S2:
  - not active -> 0.
  - active and !in_box -> 0.
  - in_box and glyph bit 1 -> FG_COLOR.
  - in_box and glyph bit 0 -> BG_COLOR.
- Glyph bit order: bit 7 of a font row byte = leftmost column.
- Reset mid-frame: outputs go to reset values immediately. After release, timing restarts at h=0, v=0 and displays spaces until the next latch point.
- Parameter legality: text box must fit inside 640x480. This is checked at elaboration only.

Decomposition:
- Shared package vga_pkg:
  - H/V visible, porch and sync constants.
  - Code constants CODE_SPACE=6'd62, CODE_A=6'd10.
  - RGB444 type/width.
- Sub-module vga_font_rom:
  - Combinational 64-entry x 8-row x 8-bit glyph table.
  - Inputs: code[5:0], row[2:0]. Output: bits[7:0].
  - Unmapped codes return 8'h00.
- Timing counters and the render pipeline stay in vga_text_render.

Test Plan:
- Reset: hold rst 10 cycles -> vga_hs=1, vga_vs=1, RGB=0. Release -> first pix_en occurs 4 clk later; hs falls 2 ticks after h_cnt reaches 656 and stays low exactly 96 ticks (384 clk); line period is 3200 clk.
- Vertical: run one frame -> vs low for exactly 2 lines (1600 ticks); frame period 420000 ticks; RGB=0 throughout all blanking.
- Frame latch: set char_codes to encode "TEST 3" (011101_001110_011100_011101_111110_000011) mid-frame at v=100 -> frame still shows spaces (box all BG 12'h00F). The next frame shows 'T' in slot 0: pixel (TEXT_X0, TEXT_Y0) = FG if the 'T' row-0 MSB is 1, and slot 4 is all BG.
- Invalid code: slot 2 = 6'd40 -> all 32x32 pixels of slot 2 = BG_COLOR; neighbours render normally.
- Box boundary: pixel at x=TEXT_X0-1 and x=TEXT_X0+192 on text rows -> RGB=0; y=TEXT_Y0+32 -> RGB=0.
- Reset mid-frame: assert rst at v=300 -> outputs at reset values within the same cycle; after release timing restarts from h=0, v=0 and the box shows spaces until v=480 latch.
